// File: rtl/btn_event_gen_pkg.sv
// btn_event_gen_pkg: button indices, sizes and the lowest-set-bit picker shared by the button front-end
package btn_event_gen_pkg;
  localparam int N_BTN               = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF           = 20;
  localparam logic [2:0] BTN_CENTER = 3'd0;
  localparam logic [2:0] BTN_TOP    = 3'd1;
  localparam logic [2:0] BTN_BOTTOM = 3'd2;
  localparam logic [2:0] BTN_LEFT   = 3'd3;
  localparam logic [2:0] BTN_RIGHT  = 3'd4;
  // Lowest set index wins, which gives center..right priority for coincident presses
  function automatic logic [2:0] lowest_idx(input logic [N_BTN-1:0] v);
    lowest_idx = 3'd0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (v[i]) lowest_idx = 3'(i);
  endfunction
endpackage

// File: rtl/btn_event_gen_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  logic             sync1_q, sync2_q, stable_q, stable_d, prev_q, pulse_q;
  logic             mism, done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Count consecutive disagreeing samples; any agreement restarts the count
  always_comb begin
    mism     = sync2_q ^ stable_q;
    done     = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
    stable_d = (mism & done) ? sync2_q : stable_q;
    cnt_d    = (mism & ~done) ? cnt_q + 1'b1 : '0;
  end
  // Synchronise, track the stable level, and pulse one cycle after it rises
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      pulse_q  <= stable_q & ~prev_q;
    end
  end
  assign level_o = stable_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: debounced button presses queued into a one-slot valid/ready event register
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             event_valid,
  output logic [2:0]       event_code,
  input  logic             event_ready,
  output logic             dropped
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [2:0]       code_q, code_d, sel;
  logic [N_BTN-1:0] pending_q, pending_d, hold, arr, req, clr;
  logic             dropped_q, dropped_d, accept, load;
  for (genvar b = 0; b < N_BTN; b++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[b]),
      .level_o(btn_level[b]),
      .pulse_o(btn_pulse[b])
    );
  end
  // Fresh pulses join the pending set directly so a press can load the slot in its own cycle;
  // a pulse for the code sitting unaccepted in the slot is merged away
  always_comb begin
    accept    = (state_q == S_FULL) & event_ready;
    hold      = (state_q == S_FULL && !event_ready) ? N_BTN'(1) << code_q : '0;
    arr       = btn_pulse & ~hold;
    req       = pending_q | arr;
    load      = ((state_q == S_EMPTY) | accept) & (|req);
    sel       = lowest_idx(req);
    clr       = load ? N_BTN'(1) << sel : '0;
    pending_d = (req & ~clr) | (arr & pending_q & clr);
    dropped_d = dropped_q | (|(btn_pulse & hold)) | (|(arr & pending_q & ~clr));
    state_d   = load ? S_FULL : accept ? S_EMPTY : state_q;
    code_d    = load ? sel : code_q;
  end
  // Slot, pending set and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      code_q    <= 3'd0;
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end
  assign event_valid = state_q == S_FULL;
  assign event_code  = code_q;
  assign dropped     = dropped_q;
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed scenarios checked against a timestamp/set-based model every cycle
module tb_btn_event_gen;
  localparam int NB = 5;
  localparam int DC = 4;
  logic          clk, reset, event_ready, event_valid, dropped;
  logic [NB-1:0] btn_raw, btn_level, btn_pulse;
  logic [2:0]    event_code;
  int total = 0;
  int bad   = 0;
  btn_event_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .event_valid(event_valid),
    .event_code (event_code),
    .event_ready(event_ready),
    .dropped    (dropped)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Model: raw seen two edges late; level flips once it has disagreed for DC edges since it last agreed
  logic [NB-1:0] m_s1, m_s2, m_stb, m_prev, m_pulse, m_pend;
  int            m_last [NB];
  bit            m_full, m_drop;
  int            m_code, cyc;
  task automatic model_step();
    bit [NB-1:0] arrived;
    int          served;
    bit          was;
    cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stb = '0; m_prev = '0; m_pulse = '0; m_pend = '0;
      m_full = 0; m_drop = 0; m_code = 0;
      for (int i = 0; i < NB; i++) m_last[i] = cyc;
      return;
    end
    if (m_full && event_ready) m_full = 0;
    arrived = '0;
    for (int i = 0; i < NB; i++)
      if (m_pulse[i]) begin
        if (m_full && m_code == i) m_drop = 1;
        else arrived[i] = 1;
      end
    served = -1;
    if (!m_full)
      for (int i = NB - 1; i >= 0; i--)
        if (m_pend[i] || arrived[i]) served = i;
    if (served >= 0) begin
      m_full = 1;
      m_code = served;
    end
    for (int i = 0; i < NB; i++) begin
      was = m_pend[i];
      if (i == served) m_pend[i] = was && arrived[i];
      else if (arrived[i]) begin
        if (was) m_drop = 1;
        m_pend[i] = 1;
      end
    end
    for (int i = 0; i < NB; i++) begin
      m_pulse[i] = m_stb[i] & ~m_prev[i];
      m_prev[i]  = m_stb[i];
      if (m_s2[i] == m_stb[i]) m_last[i] = cyc;
      else if (cyc - m_last[i] == DC) begin
        m_stb[i]  = m_s2[i];
        m_last[i] = cyc;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask
  always @(posedge clk) model_step();
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  // One cycle: wait for the falling edge and compare every output with the model
  task automatic tick();
    @(negedge clk);
    chk("m_level", int'(btn_level), int'(m_stb));
    chk("m_pulse", int'(btn_pulse), int'(m_pulse));
    chk("m_valid", int'(event_valid), int'(m_full));
    if (m_full) chk("m_code", int'(event_code), m_code);
    chk("m_dropped", int'(dropped), int'(m_drop));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int npulse, tp, nev;
    reset = 1'b1; btn_raw = '0; event_ready = 1'b1;
    // Held through reset: all five pulse together, then events 0..4 back to back
    btn_raw = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pulse", int'(btn_pulse), 0);
      chk("rst_valid", int'(event_valid), 0);
      chk("rst_level", int'(btn_level), 0);
      chk("rst_dropped", int'(dropped), 0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 6) chk("t1_pulse_early", int'(btn_pulse), 0);
      if (t == 7) chk("t1_pulse", int'(btn_pulse), 31);
      if (t >= 8 && t <= 12) begin
        chk("t1_valid", int'(event_valid), 1);
        chk("t1_code", int'(event_code), t - 8);
      end
      if (t == 13) chk("t1_idle", int'(event_valid), 0);
    end
    btn_raw = '0; run(10);
    // Single center press
    btn_raw[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 6) chk("t2_pulse_early", int'(btn_pulse), 0);
      if (t == 7) chk("t2_pulse", int'(btn_pulse), 1);
      if (t == 8) begin
        chk("t2_pulse_once", int'(btn_pulse), 0);
        chk("t2_valid", int'(event_valid), 1);
        chk("t2_code", int'(event_code), 0);
      end
      if (t == 9) chk("t2_idle", int'(event_valid), 0);
    end
    chk("t2_dropped", int'(dropped), 0);
    btn_raw = '0; run(10);
    // Bouncing top button, then held: one pulse six edges after the final rise is sampled
    npulse = 0; tp = 0; nev = 0;
    for (int t = 1; t <= 30; t++) begin
      btn_raw[1] = (t > 12) ? 1'b1 : (((t - 1) / 2) % 2 == 0);
      tick();
      if (btn_pulse[1]) begin npulse++; tp = t; end
      if (event_valid && event_code == 3'd1) nev++;
    end
    chk("t3_npulse", npulse, 1);
    chk("t3_pulse_t", tp, 19);
    chk("t3_nevents", nev, 1);
    btn_raw = '0; run(10);
    // Left and right together with back-pressure
    event_ready = 1'b0; btn_raw = 5'b11000;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 7) chk("t4_pulse", int'(btn_pulse), 24);
      if (t >= 8) begin
        chk("t4_valid", int'(event_valid), 1);
        chk("t4_code_hold", int'(event_code), 3);
      end
    end
    event_ready = 1'b1;
    tick(); chk("t4_valid2", int'(event_valid), 1); chk("t4_code2", int'(event_code), 4);
    tick(); chk("t4_idle", int'(event_valid), 0); chk("t4_dropped", int'(dropped), 0);
    btn_raw = '0; run(10);
    // Slot holds top; center pressed twice while pending -> merged and flagged
    event_ready = 1'b0; btn_raw = 5'b00010; run(8);
    chk("t5_slot", int'(event_code), 1);
    btn_raw[0] = 1'b1; run(8); chk("t5_drop_first", int'(dropped), 0);
    btn_raw[0] = 1'b0; run(8);
    btn_raw[0] = 1'b1; run(8); chk("t5_drop_second", int'(dropped), 1);
    chk("t5_valid", int'(event_valid), 1); chk("t5_code_hold", int'(event_code), 1);
    event_ready = 1'b1;
    tick(); chk("t5_valid2", int'(event_valid), 1); chk("t5_code2", int'(event_code), 0);
    tick(); chk("t5_idle", int'(event_valid), 0);
    btn_raw = '0; run(10); chk("t5_sticky", int'(dropped), 1);
    // Reset while bottom is mid-debounce
    reset = 1'b1; tick(); chk("t6_rst_drop", int'(dropped), 0);
    reset = 1'b0; btn_raw[2] = 1'b1; run(4);
    reset = 1'b1; tick(); chk("t6_rst_level", int'(btn_level), 0); chk("t6_rst_pulse", int'(btn_pulse), 0);
    reset = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 6) chk("t6_pulse_early", int'(btn_pulse), 0);
      if (t == 7) chk("t6_pulse", int'(btn_pulse), 4);
      if (t == 8) begin chk("t6_valid", int'(event_valid), 1); chk("t6_code", int'(event_code), 2); end
    end
    chk("t6_dropped", int'(dropped), 0);
    btn_raw = '0; run(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
